// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch-side initiator for a combinational, word-addressed instruction
//   memory. Holds the program counter, drives it as the byte address to
//   memory, buffers returned words in a small FIFO and presents {pc, instr}
//   to decode over a valid/ready handshake. Supports redirect with flush,
//   halt, and a sticky fault for misaligned or out-of-range fetch addresses.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous active-high reset
//   imem_addr      out  32  byte address to instruction memory (= pc register)
//   imem_instr     in   32  word returned for imem_addr in the same cycle
//   redirect_valid in   1   redirect request (flushes buffer)
//   redirect_pc    in   32  redirect target byte address
//   halt           in   1   suspend new fetches while high
//   if_valid       out  1   buffer head valid
//   if_ready       in   1   decode accepts head
//   if_instr       out  32  head instruction (0 when empty)
//   if_pc          out  32  head byte address (0 when empty)
//   if_fault       out  1   sticky fetch fault
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_CNT   = PW'(FIFO_DEPTH);
  localparam logic [31:0]   MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     pc_buf_q    [FIFO_DEPTH];
  logic [31:0]     instr_buf_q [FIFO_DEPTH];

  logic [PW-1:0]   count_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic [31:0]     word_idx_s;
  logic            fault_cond_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_s      = wr_ptr_q - rd_ptr_q;
  assign empty_s      = (count_s == {PW{1'b0}});
  assign full_s       = (count_s == DEPTH_CNT);
  assign pop_s        = (!empty_s) && if_ready;
  assign word_idx_s   = {2'b00, pc_q[31:2]};
  assign fault_cond_s = (pc_q[1:0] != 2'b00) || (word_idx_s >= MEM_WORDS_W);

  assign imem_addr = pc_q;
  assign if_valid  = !empty_s;
  assign if_fault  = (state_q == ST_FAULT);

  // Head of buffer presented to decode; zeroed when nothing is buffered.
  always_comb begin
    if_instr = 32'h0000_0000;
    if_pc    = 32'h0000_0000;
    if (!empty_s) begin
      if_instr = instr_buf_q[rd_ptr_q[AW-1:0]];
      if_pc    = pc_buf_q[rd_ptr_q[AW-1:0]];
    end else begin
      if_instr = 32'h0000_0000;
      if_pc    = 32'h0000_0000;
    end
  end

  // Next-state, pc and pointer logic. Redirect wins over everything but reset;
  // it flushes the buffer (discarding any same-cycle pop) and never pushes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_s   = 1'b0;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      state_d  = halt ? ST_HALTED : ST_FETCH;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case (state_q)
        ST_FETCH: begin
          // The address check gates the push; a fault outranks halt.
          if (fault_cond_s) begin
            state_d = ST_FAULT;
          end else if (halt) begin
            state_d = ST_HALTED;
          end else if (!full_s || pop_s) begin
            push_s   = 1'b1;
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HALTED: begin
          state_d = halt ? ST_HALTED : ST_FETCH;
        end
        ST_FAULT: begin
          // Only a redirect or reset leaves FAULT.
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Control registers: state, pc and buffer pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer storage: captures {pc, imem_instr} on a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_buf_q[i]    <= 32'h0000_0000;
        instr_buf_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_buf_q[wr_ptr_q[AW-1:0]]    <= pc_q;
      instr_buf_q[wr_ptr_q[AW-1:0]] <= imem_instr;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_buf_q[i]    <= pc_buf_q[i];
        instr_buf_q[i] <= instr_buf_q[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        halt = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  // Bench memory contents: word0/word1 fixed, others tagged with their index.
  function automatic logic [31:0] memw(input int k);
    if (k == 0)      return 32'hDEAD_BEEF;
    else if (k == 1) return 32'hCAFE_BABE;
    else             return 32'hA000_0000 | 32'(k);
  endfunction

  // Combinational 256-word memory.
  always_comb begin
    if (imem_addr[31:10] == 22'd0) imem_instr = memw(int'(imem_addr[9:2]));
    else                           imem_instr = 32'hBAD0_BAD0;
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        ef;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic h, input logic rdy, input logic chk,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] ei, input logic [31:0] ea,
                              input logic ef);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.halt = h; v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.epc = epc; v.ei = ei; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, compare at the falling
  // edge. Expected values describe the state in force during this cycle.
  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    halt           = v.halt;
    if_ready       = v.rdy;
    @(negedge clk);
    if (v.chk) begin
      cmp({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, v.ev});
      cmp({tag, ".if_pc"},     if_pc,             v.epc);
      cmp({tag, ".if_instr"},  if_instr,          v.ei);
      cmp({tag, ".imem_addr"}, imem_addr,         v.ea);
      cmp({tag, ".if_fault"},  {31'd0, if_fault}, {31'd0, v.ef});
    end
  endtask

  vec_t tbl [25];

  initial begin
    // rst rv rpc halt rdy chk | valid pc instr addr fault
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,   1'b0);
    // reset state, backpressure fills the 2-entry buffer
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        32'h0,   1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEAD_BEEF, 32'h4,  1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEAD_BEEF, 32'h8,  1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEAD_BEEF, 32'h8,  1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'hDEAD_BEEF, 32'h8,  1'b0);
    // release: 0, 4, 8 in order
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h0,  32'hDEAD_BEEF, 32'h8,  1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h4,  32'hCAFE_BABE, 32'hC,  1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h8,  memw(2),       32'h10, 1'b0);
    // redirect to 0x40 with full buffer
    tbl[9]  = mk(1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  memw(2),       32'h10, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h40, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h40, memw(16),      32'h44, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h44, memw(17),      32'h48, 1'b0);
    // halt for 3 cycles: drain, address frozen, resume at frozen address
    tbl[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b1, 32'h48, memw(18),      32'h4C, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h4C, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h4C, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h4C, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h4C, 1'b0);
    // misaligned redirect -> fault
    tbl[18] = mk(1'b0, 1'b1, 32'h42,  1'b0, 1'b1, 1'b1, 1'b1, 32'h4C, memw(19),      32'h50, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h42, 1'b0);
    // out-of-range redirect (word 256) -> fault
    tbl[20] = mk(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h42, 1'b1);
    tbl[21] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h400, 1'b0);
    // good redirect clears the fault and resumes at 8
    tbl[22] = mk(1'b0, 1'b1, 32'h8,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h400, 1'b1);
    tbl[23] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0,         32'h8,  1'b0);
    tbl[24] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h8,  memw(2),       32'hC,  1'b0);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Fault stickiness: bad redirect, then 10 cycles held with halt toggling.
    step(mk(1'b0, 1'b1, 32'h42, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC, memw(3), 32'h10, 1'b0), "flt_redir");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0,   32'h42, 1'b0), "flt_check");
    for (int k = 0; k < 10; k++) begin
      step(mk(1'b0, 1'b0, 32'h0, logic'(k[0]), 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h42, 1'b1),
           $sformatf("flt_hold%0d", k));
    end
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h42, 1'b1), "flt_nohalt");

    // Reset mid-operation with full buffer, redirect and halt in the same cycle.
    step(mk(1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,         32'h42, 1'b1), "rst_a");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,         32'h0,  1'b0), "rst_b");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h4,  1'b0), "rst_c");
    step(mk(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h8,  1'b0), "rst_d");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0,         32'h0,  1'b0), "rst_e");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h4,  1'b0), "rst_f");
    step(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'hCAFE_BABE, 32'h8,  1'b0), "rst_g");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
